m_unit_seq: RTL and testbench
=============================

# m_unit_seq

Parametrised successor to the M-extension PCPI controller: a self-contained multiply/divide coprocessor with controller and datapath in one block. It is generic in `XLEN` and in divider bits retired per cycle. It latches operands at accept time and produces RISC-V-exact results for divide-by-zero and signed overflow. It sits on the PicoRV32 PCPI port alongside the core; only instructions with opcode `0110011` and funct7 `0000001` are claimed.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; legal values 32 or 64.
- `DIV_K`, default 1: quotient bits resolved per divide cycle; legal values 1, 2, 4; must divide `XLEN`.

Ports:
- `clk`  in  1  — the single clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `pcpi_valid`  in  1  — request valid; held by the core until `pcpi_ready`.
- `pcpi_insn`  in  32  — instruction word.
- `pcpi_rs1`  in  XLEN  — operand A.
- `pcpi_rs2`  in  XLEN  — operand B.
- `pcpi_wr`  out  1  — write-back enable; pulses with `pcpi_ready`.
- `pcpi_rd`  out  XLEN  — result; valid only while `pcpi_ready`=1, otherwise 0.
- `pcpi_wait`  out  1  — busy; high in SETUP, MUL, DIV and FIX.
- `pcpi_ready`  out  1  — one-cycle completion pulse.

## Operation
- States: IDLE, SETUP, MUL, DIV, FIX, DONE.
- **IDLE:** a hit is `pcpi_valid` & opcode match & funct7 match. On a hit, the next edge:
  - registers func3, `pcpi_rs1` and `pcpi_rs2`;
  - moves to SETUP.
  - Operands are never re-read after accept. Non-hits are ignored.
- **SETUP:** computes operand sign flags and magnitudes.
  - Signed ops: MULH and MULHSU treat rs1 as signed. DIV and REM treat both operands as signed.
  - Detects special cases: divisor 0 (DIV/DIVU/REM/REMU), and signed overflow (DIV/REM with rs1 = most negative, rs2 = all ones).
  - Next state: MUL for func3[2]=0. For divides, DIV, or FIX if early-out applies (see Configuration).
- **MUL:** one cycle. Computes the (XLEN+1)×(XLEN+1) signed product of the sign-/zero-extended operands into a 2·XLEN product register. Then goes to FIX.
- **DIV:** restoring division on magnitudes, `DIV_K` steps per cycle, for `XLEN/DIV_K` cycles, with an iteration counter of width clog2(XLEN/DIV_K)+1. Goes to FIX after the last iteration.
- **FIX:** writes the result register.
  - MUL → product[XLEN-1:0].
  - MULH/MULHSU/MULHU → product[2·XLEN-1:XLEN].
  - DIV/DIVU → quotient, negated if DIV and the operand signs differ.
  - REM/REMU → remainder, negated if REM and rs1 is negative.
  - Divide-by-zero overrides: quotient = all ones; remainder = rs1.
  - Overflow overrides: quotient = rs1; remainder = 0.
  - These overrides apply regardless of the macro.
- **DONE:** `pcpi_ready`=1, `pcpi_wr`=1, `pcpi_rd`=result for exactly one cycle, then IDLE. A request present in DONE is not accepted; IDLE must be re-entered first.
- **Abort:** if `pcpi_valid` is 0 in SETUP, MUL, DIV or FIX, the next state is IDLE and no ready is issued. In-flight registers are discarded.

## Timing
- Accept edge = edge at end of cycle 0; SETUP is cycle 1.
- Multiply: `pcpi_ready` in cycle 4.
- Divide: `pcpi_ready` in cycle 3 + `XLEN/DIV_K`. For XLEN=32: 35 (K=1), 19 (K=2), 11 (K=4).
- Early-out divide: `pcpi_ready` in cycle 3.
- `pcpi_wait` is registered: low in cycle 0, high from cycle 1 up to and including the FIX cycle, low in DONE.
- **Reset:** `reset` sampled high at an edge forces IDLE. It clears the counter, func3 and all operand, product and result registers. After that edge `pcpi_wr`, `pcpi_ready` and `pcpi_wait` are 0 and `pcpi_rd` is 0. This applies in any state, including mid-DIV; the aborted op produces no ready.
- Back-to-back: minimum 1 IDLE cycle between DONE and the next accept edge.

## Configuration
- `M_UNIT_EARLY_OUT_EN` defined: special-case divides go SETUP→FIX directly (ready in cycle 3).
- Undefined: special cases run the full DIV iteration. The counter and divider run as normal, and FIX applies the override. Results are identical; only latency differs.

## Test plan
- MUL, XLEN=32, rs1=7, rs2=0xFFFFFFFD → `pcpi_rd`=0xFFFFFFEB with `pcpi_wr`=1 in cycle 4; `pcpi_wait` high cycles 1–3.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; ready in cycle 35 at DIV_K=1 and cycle 19 at DIV_K=2. Operands driven to garbage after accept do not change the result.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Ready in cycle 3 with `M_UNIT_EARLY_OUT_EN`, cycle 35 without.
- Abort: DIV accepted, `pcpi_valid` dropped in cycle 10 → no `pcpi_ready`, IDLE in cycle 11. A following MUL 3×4 → 12 in 4 cycles.
- `reset`=1 in cycle 8 of a DIV → from the next cycle all outputs 0, state IDLE. Funct7=0000000 or opcode mismatch with `pcpi_valid`=1 → `pcpi_wait` stays 0 and no response.

Source files
------------

// File: rtl/m_unit_seq.sv
// m_unit_seq: multiply/divide coprocessor for the PicoRV32 PCPI port.
// Controller and datapath live in one block. It claims only instructions
// with opcode 0110011 and funct7 0000001 (the RISC-V M extension).
// Operands are latched when a request is accepted and are never re-read.
// Divide-by-zero and signed-overflow results follow the RISC-V rules.
//
// Parameters:
//   XLEN  - operand/result width (32 or 64)
//   DIV_K - quotient bits resolved per divide cycle (1, 2 or 4; divides XLEN)
//
// Optional feature macro: M_UNIT_EARLY_OUT_EN
//   When defined, a divide by zero or a signed-overflow divide skips the
//   iteration and goes SETUP -> FIX. The results are the same either way;
//   only the latency changes.
//
// Ports:
//   clk        in   1     clock, rising edge
//   reset      in   1     synchronous active-high reset
//   pcpi_valid in   1     request valid, held until pcpi_ready
//   pcpi_insn  in   32    instruction word
//   pcpi_rs1   in   XLEN  operand A
//   pcpi_rs2   in   XLEN  operand B
//   pcpi_wr    out  1     write-back enable, pulses with pcpi_ready
//   pcpi_rd    out  XLEN  result, zero unless pcpi_ready
//   pcpi_wait  out  1     busy in SETUP/MUL/DIV/FIX
//   pcpi_ready out  1     one-cycle completion pulse
module m_unit_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DIV_K = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int unsigned ITERS = XLEN / DIV_K;
  localparam int unsigned CNT_W = $clog2(ITERS) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              ready_q, ready_d;
  logic              wait_q, wait_d;

  // Request decode: opcode OP with funct7 MULDIV.
  logic hit;
  assign hit = pcpi_valid
            && (pcpi_insn[6:0] == 7'b0110011)
            && (pcpi_insn[31:25] == 7'b0000001);

  // Register/immediate fields of the instruction are not needed here.
  logic unused_insn;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Operand signedness from the latched func3:
  //   rs1 signed for MULH, MULHSU, DIV, REM; rs2 signed for MULH, DIV, REM.
  logic is_div, div_signed, a_signed, b_signed;
  assign is_div     = func3_q[2];
  assign div_signed = func3_q[2] & ~func3_q[0];
  assign a_signed   = (func3_q == 3'b001) || (func3_q == 3'b010) || div_signed;
  assign b_signed   = (func3_q == 3'b001) || div_signed;

  // Sign flags and magnitudes; -MIN wraps to MIN, which is the right magnitude.
  logic            a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag, b_mag;
  assign a_neg_c = a_signed & rs1_q[XLEN-1];
  assign b_neg_c = b_signed & rs2_q[XLEN-1];
  assign a_mag   = a_neg_c ? (~rs1_q + XLEN'(1)) : rs1_q;
  assign b_mag   = b_neg_c ? (~rs2_q + XLEN'(1)) : rs2_q;

  // Special-case detection for divides.
  logic dz_c, ovf_c;
  assign dz_c  = is_div && (rs2_q == '0);
  assign ovf_c = div_signed
              && (rs1_q == {1'b1, {(XLEN-1){1'b0}}})
              && (&rs2_q);

  // Multiplier: (XLEN+1)-bit sign/zero-extended operands, extended to 2*XLEN;
  // the 2*XLEN-bit truncated signed product is exact for these operands.
  logic signed [PW-1:0] a_sx, b_sx;
  logic        [PW-1:0] mul_res;
  assign a_sx    = $signed({{XLEN{a_neg_q}}, rs1_q});
  assign b_sx    = $signed({{XLEN{b_neg_q}}, rs2_q});
  assign mul_res = a_sx * b_sx;

  // Restoring divider: DIV_K shift/compare/subtract steps per cycle.
  // quo_q holds the remaining dividend bits in its upper part and the
  // quotient bits accumulated so far in its lower part.
  logic [XLEN-1:0] div_quo, div_rem;
  logic [XLEN:0]   div_shift, div_trial;
  always_comb begin
    div_quo   = quo_q;
    div_rem   = rem_q;
    div_shift = '0;
    div_trial = '0;
    for (int unsigned i = 0; i < DIV_K; i++) begin
      div_shift = {div_rem, div_quo[XLEN-1]};
      div_trial = div_shift - {1'b0, dvs_q};
      div_quo   = {div_quo[XLEN-2:0], ~div_trial[XLEN]};
      div_rem   = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
    end
  end

  // Final result selection, including the RISC-V special-case overrides.
  logic [XLEN-1:0] fix_res;
  always_comb begin
    fix_res = '0;
    case (func3_q)
      3'b000: fix_res = prod_q[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011: fix_res = prod_q[PW-1:XLEN];
      3'b100,
      3'b101: begin
        if (dz_q)                 fix_res = '1;
        else if (ovf_q)           fix_res = rs1_q;
        else if (a_neg_q ^ b_neg_q) fix_res = ~quo_q + XLEN'(1);
        else                      fix_res = quo_q;
      end
      default: begin
        if (dz_q)         fix_res = rs1_q;
        else if (ovf_q)   fix_res = '0;
        else if (a_neg_q) fix_res = ~rem_q + XLEN'(1);
        else              fix_res = rem_q;
      end
    endcase
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rd_d    = '0;
    ready_d = 1'b0;
    wait_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          func3_d = pcpi_insn[14:12];
          rs1_d   = pcpi_rs1;
          rs2_d   = pcpi_rs2;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        a_neg_d = a_neg_c;
        b_neg_d = b_neg_c;
        dz_d    = dz_c;
        ovf_d   = ovf_c;
        dvs_d   = b_mag;
        quo_d   = a_mag;
        rem_d   = '0;
        cnt_d   = '0;
        if (!pcpi_valid) begin
          state_d = S_IDLE;
        end else if (!is_div) begin
          state_d = S_MUL;
`ifdef M_UNIT_EARLY_OUT_EN
        end else if (dz_c || ovf_c) begin
          state_d = S_FIX;
`endif
        end else begin
          state_d = S_DIV;
        end
      end

      S_MUL: begin
        prod_d  = mul_res;
        state_d = pcpi_valid ? S_FIX : S_IDLE;
      end

      S_DIV: begin
        quo_d = div_quo;
        rem_d = div_rem;
        if (!pcpi_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FIX: begin
        if (pcpi_valid) begin
          rd_d    = fix_res;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flags track the state being entered so they are registered.
    wait_d  = (state_d == S_SETUP) || (state_d == S_MUL)
           || (state_d == S_DIV)   || (state_d == S_FIX);
    ready_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      func3_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      wait_q  <= wait_d;
    end
  end

  assign pcpi_rd    = rd_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_wait  = wait_q;

endmodule

// File: tb/tb_m_unit_seq.sv
// Self-checking bench for m_unit_seq (XLEN=32). Expected results come from a
// 64-bit behavioural model and are queued when a request is issued, then
// popped and compared when the unit raises pcpi_ready.
module tb_m_unit_seq;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DIV_K   = 1;
  localparam int          DIV_LAT = 3 + int'(XLEN / DIV_K);
`ifdef M_UNIT_EARLY_OUT_EN
  localparam int          SPC_LAT = 3;
`else
  localparam int          SPC_LAT = DIV_LAT;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  m_unit_seq #(.XLEN(XLEN), .DIV_K(DIV_K)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Behavioural reference using native 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb2, sp;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (f3)
      3'd0: begin sp = sa * sb2; return sp[31:0]; end
      3'd1: begin sp = sa * sb2; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        sp = sa / sb2; return sp[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        sp = sa % sb2; return sp[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (!f3[2]) return 4;
    return special ? SPC_LAT : DIV_LAT;
  endfunction

  // Issue one request, garble operands after accept, and check the response.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    int   c;
    bit   got;
    bit   busy_bad;
    e.rd  = ref_res(f3, a, b);
    e.cyc = exp_lat(f3, a, b);
    sb.push_back(e);
    busy_bad   = (pcpi_wait !== 1'b0);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h01, f3, 7'h33);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    c   = 0;
    got = 1'b0;
    while (!got && c < 200) begin
      step();
      c++;
      if (c == 1) begin
        pcpi_rs1 = $urandom;
        pcpi_rs2 = $urandom;
      end
      if (pcpi_ready === 1'b1) begin
        got        = 1'b1;
        pcpi_valid = 1'b0;
        e          = sb.pop_front();
        chk({tag, "_rd"}, 64'(pcpi_rd), 64'(e.rd));
        chk({tag, "_cycle"}, 64'(c), 64'(e.cyc));
        chk({tag, "_wr_wait"}, {62'd0, pcpi_wr, pcpi_wait}, 64'd2);
      end else if (pcpi_wait !== 1'b1 || pcpi_rd !== '0 || pcpi_wr !== 1'b0) begin
        busy_bad = 1'b1;
      end
    end
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    chk({tag, "_ready_seen"}, 64'(got), 64'd1);
    if (!got && sb.size() > 0) void'(sb.pop_front());
    pcpi_valid = 1'b0;
    step();
  endtask

  // Watch for a stray response over n cycles.
  task automatic quiet(input string tag, input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_wait !== 1'b0 || pcpi_rd !== '0)
        bad = 1'b1;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    bit   busy_bad;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    step(); step(); step();
    chk("reset_rd", 64'(pcpi_rd), 64'd0);
    chk("reset_flags", {61'd0, pcpi_wr, pcpi_ready, pcpi_wait}, 64'd0);
    reset = 1'b0;
    step();

    // Directed multiplies.
    do_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD);
    do_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000);
    do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);

    // Directed divides.
    do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2);
    do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2);
    do_op("divu_5_0",   3'd5, 32'd5,          32'd0);
    do_op("remu_5_0",   3'd7, 32'd5,          32'd0);
    do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    do_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    do_op("div_m9_0",   3'd4, 32'hFFFF_FFF7,  32'd0);
    do_op("rem_m9_0",   3'd6, 32'hFFFF_FFF7,  32'd0);
    do_op("divu_big",   3'd5, 32'hFFFF_FFF0,  32'd3);
    do_op("rem_7_m3",   3'd6, 32'd7,          32'hFFFF_FFFD);

    // Abort: DIV accepted, valid dropped in cycle 10.
    busy_bad   = 1'b0;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h01, 3'd4, 7'h33);
    pcpi_rs1   = 32'd1000;
    pcpi_rs2   = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (pcpi_wait !== 1'b1 || pcpi_ready !== 1'b0) busy_bad = 1'b1;
    end
    chk("abort_busy", 64'(busy_bad), 64'd0);
    pcpi_valid = 1'b0;
    step();
    chk("abort_wait_c11", 64'(pcpi_wait), 64'd0);
    quiet("abort_no_ready", 40);
    do_op("mul_3_4", 3'd0, 32'd3, 32'd4);

    // Reset asserted in cycle 8 of a DIV.
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h01, 3'd5, 7'h33);
    pcpi_rs1   = 32'd12345;
    pcpi_rs2   = 32'd17;
    for (int c = 1; c <= 8; c++) step();
    chk("rst_mid_wait_before", 64'(pcpi_wait), 64'd1);
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    step();
    chk("rst_mid_flags", {61'd0, pcpi_wr, pcpi_ready, pcpi_wait}, 64'd0);
    chk("rst_mid_rd", 64'(pcpi_rd), 64'd0);
    reset = 1'b0;
    quiet("rst_mid_no_ready", 40);
    do_op("mul_after_rst", 3'd0, 32'hFFFF_FFFF, 32'd5);

    // Non-hits are ignored.
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'h00, 3'd0, 7'h33);
    pcpi_rs1   = 32'd9;
    pcpi_rs2   = 32'd9;
    quiet("nohit_funct7", 6);
    pcpi_insn  = mk_insn(7'h01, 3'd0, 7'h13);
    quiet("nohit_opcode", 6);
    pcpi_valid = 1'b0;
    step();

    // Random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      do_op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
